// File: rtl/vga_coord_gen_if.sv
// vga_coord_gen_if: pixel-timing bus from the coordinate generator to the
// overlay compare blocks, the colour mux and the output pins.
// master = timing generator, slave = any consumer of the timing.
`timescale 1ns/1ps

interface vga_coord_gen_if;
    logic [11:0] VGA_horzCoord;
    logic [11:0] VGA_vertCoord;
    logic        HSYNC;
    logic        VSYNC;
    logic        VIDEO_ACTIVE;
    logic        FRAME_START;
    logic [15:0] FRAME_COUNT;

    modport master (
        output VGA_horzCoord,
        output VGA_vertCoord,
        output HSYNC,
        output VSYNC,
        output VIDEO_ACTIVE,
        output FRAME_START,
        output FRAME_COUNT
    );

    modport slave (
        input VGA_horzCoord,
        input VGA_vertCoord,
        input HSYNC,
        input VSYNC,
        input VIDEO_ACTIVE,
        input FRAME_START,
        input FRAME_COUNT
    );
endinterface

// File: rtl/vga_coord_gen.sv
// vga_coord_gen: horizontal/vertical pixel counters with HSYNC, VSYNC and
// VIDEO_ACTIVE qualifiers, an optional sync delay line and a frame-start pulse.
// Default timing is 1280x1024 @ 60 Hz (108 MHz pixel clock).
// Optional feature macro: VGA_FRAME_COUNT_EN -- when defined, FRAME_COUNT
// counts completed frames; when undefined it is tied to zero.
`timescale 1ns/1ps

module vga_coord_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 48,
    parameter int H_SYNC     = 112,
    parameter int H_BP       = 248,
    parameter int V_ACTIVE   = 1024,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 38,
    parameter bit SYNC_POL   = 1'b1,
    parameter int SYNC_DELAY = 0
) (
    input  logic           CLK,
    input  logic           RESETN,
    input  logic           CLK_EN,
    vga_coord_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All timing compares are done on 12-bit unsigned values.
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEGIN   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEGIN   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Refuse to elaborate timings the 12-bit counters cannot represent.
    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
            $error("vga_coord_gen: H_TOTAL and V_TOTAL must be <= 4096");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_coord_gen: SYNC_DELAY must be in 0..4");
        end
    endgenerate

    // Half-open window test: lo <= c < hi.
    function automatic logic in_window(input logic [11:0] c,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    // Map an "inside sync pulse" flag onto the configured pin polarity.
    function automatic logic sync_level(input logic in_pulse);
        return in_pulse ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [11:0] h_p0;
    logic [11:0] v_p0;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        wrap_frame;
    logic        fs_p0;

    // Index 0 is coincident with the coordinates; index SYNC_DELAY drives the pins.
    logic        hs_p [0:SYNC_DELAY];
    logic        vs_p [0:SYNC_DELAY];
    logic        va_p [0:SYNC_DELAY];

    // Next-state counts; qualifiers are decoded from these so that the
    // registered qualifier lines up with the registered coordinate.
    always_comb begin
        h_nxt      = h_p0 + 12'd1;
        v_nxt      = v_p0;
        wrap_frame = 1'b0;
        if (h_p0 == H_LAST) begin
            h_nxt = '0;
            if (v_p0 == V_LAST) begin
                v_nxt      = '0;
                wrap_frame = 1'b1;
            end else begin
                v_nxt = v_p0 + 12'd1;
            end
        end
    end

    // Counters, undelayed qualifiers, sync delay line and frame-start pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            h_p0  <= '0;
            v_p0  <= '0;
            fs_p0 <= 1'b0;
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                hs_p[i] <= ~SYNC_POL;
                vs_p[i] <= ~SYNC_POL;
                va_p[i] <= 1'b0;
            end
        end else begin
            // The pulse lasts one CLK even when CLK_EN is held high for only one cycle.
            fs_p0 <= 1'b0;
            if (CLK_EN) begin
                h_p0    <= h_nxt;
                v_p0    <= v_nxt;
                fs_p0   <= wrap_frame;
                hs_p[0] <= sync_level(in_window(h_nxt, HS_BEGIN, HS_END));
                vs_p[0] <= sync_level(in_window(v_nxt, VS_BEGIN, VS_END));
                va_p[0] <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
                // ---- sync delay stages: advance only on pixel enables ----
                for (int i = 1; i <= SYNC_DELAY; i++) begin
                    hs_p[i] <= hs_p[i-1];
                    vs_p[i] <= vs_p[i-1];
                    va_p[i] <= va_p[i-1];
                end
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    // Completed-frame counter, stepping together with FRAME_START and wrapping at 65535.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            frame_cnt <= '0;
        end else if (CLK_EN && wrap_frame) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vga.FRAME_COUNT = frame_cnt;
`else
    assign vga.FRAME_COUNT = 16'd0;
`endif

    assign vga.VGA_horzCoord = h_p0;
    assign vga.VGA_vertCoord = v_p0;
    assign vga.FRAME_START   = fs_p0;
    assign vga.HSYNC         = hs_p[SYNC_DELAY];
    assign vga.VSYNC         = vs_p[SYNC_DELAY];
    assign vga.VIDEO_ACTIVE  = va_p[SYNC_DELAY];

endmodule

// File: tb/tb_vga_coord_gen.sv
// tb_vga_coord_gen: directed bench for vga_coord_gen. Three instances share
// clock, reset and CLK_EN: default 1280x1024 timing, the same timing with
// SYNC_DELAY = 2, and a tiny 16x8 timing (active-low sync) used for the
// frame-level and gating sequences so a full frame fits in a few cycles.
`timescale 1ns/1ps

module tb_vga_coord_gen;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    logic CLK_EN = 1'b1;

    int errors = 0;
    int checks = 0;

`ifdef VGA_FRAME_COUNT_EN
    localparam int FC_ONE = 1;
    localparam int FC_TWO = 2;
`else
    localparam int FC_ONE = 0;
    localparam int FC_TWO = 0;
`endif

    always #5 CLK = ~CLK;

    vga_coord_gen_if bus_d ();
    vga_coord_gen_if bus_y ();
    vga_coord_gen_if bus_s ();

    vga_coord_gen u_dflt (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CLK_EN (CLK_EN),
        .vga    (bus_d)
    );

    vga_coord_gen #(.SYNC_DELAY(2)) u_dly (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CLK_EN (CLK_EN),
        .vga    (bus_y)
    );

    // 16 x 8 frame: HSYNC at h 10..12, VSYNC on lines 5..6, active 8 x 4.
    vga_coord_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SYNC_DELAY(0)
    ) u_small (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CLK_EN (CLK_EN),
        .vga    (bus_s)
    );

    typedef struct {
        logic rstn;
        logic en;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic va;
        logic fs;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_va, d_hs, d_vs, d_hs_first, d_hs_last;
        int y_hs_first, y_va_fall;
        logic y_va_prev;
        int s_va, s_vs, s_vs_first, s_fs;
        int fs_n, fs_first, fs_second;

        // rstn en  h  v  hs vs va fs   (small instance, active-low sync)
        tbl[0]  = '{1, 1,  1, 0, 1, 1, 1, 0};
        tbl[1]  = '{1, 1,  2, 0, 1, 1, 1, 0};
        tbl[2]  = '{1, 1,  3, 0, 1, 1, 1, 0};
        tbl[3]  = '{1, 0,  3, 0, 1, 1, 1, 0};
        tbl[4]  = '{1, 1,  4, 0, 1, 1, 1, 0};
        tbl[5]  = '{1, 0,  4, 0, 1, 1, 1, 0};
        tbl[6]  = '{1, 1,  5, 0, 1, 1, 1, 0};
        tbl[7]  = '{1, 1,  6, 0, 1, 1, 1, 0};
        tbl[8]  = '{1, 1,  7, 0, 1, 1, 1, 0};
        tbl[9]  = '{1, 1,  8, 0, 1, 1, 0, 0};
        tbl[10] = '{1, 1,  9, 0, 1, 1, 0, 0};
        tbl[11] = '{1, 1, 10, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 10, 0, 0, 1, 0, 0};
        tbl[13] = '{1, 1, 11, 0, 0, 1, 0, 0};
        tbl[14] = '{1, 1, 12, 0, 0, 1, 0, 0};
        tbl[15] = '{1, 1, 13, 0, 1, 1, 0, 0};
        tbl[16] = '{1, 1, 14, 0, 1, 1, 0, 0};
        tbl[17] = '{1, 1, 15, 0, 1, 1, 0, 0};
        tbl[18] = '{1, 1,  0, 1, 1, 1, 1, 0};
        tbl[19] = '{1, 1,  1, 1, 1, 1, 1, 0};
        tbl[20] = '{0, 1,  0, 0, 1, 1, 0, 0};
        tbl[21] = '{1, 1,  1, 0, 1, 1, 1, 0};

        // ---------------- reset values ----------------
        RESETN = 1'b0;
        CLK_EN = 1'b1;
        repeat (3) step();
        chk("rst dflt h",  int'(bus_d.VGA_horzCoord), 0);
        chk("rst dflt v",  int'(bus_d.VGA_vertCoord), 0);
        chk("rst dflt hs", int'(bus_d.HSYNC), 0);
        chk("rst dflt vs", int'(bus_d.VSYNC), 0);
        chk("rst dflt va", int'(bus_d.VIDEO_ACTIVE), 0);
        chk("rst dflt fs", int'(bus_d.FRAME_START), 0);
        chk("rst dflt fc", int'(bus_d.FRAME_COUNT), 0);
        chk("rst dly hs",  int'(bus_y.HSYNC), 0);
        chk("rst dly va",  int'(bus_y.VIDEO_ACTIVE), 0);
        chk("rst small hs", int'(bus_s.HSYNC), 1);
        chk("rst small vs", int'(bus_s.VSYNC), 1);

        // ---------------- table: release, gating, line wrap, sync reset ----------------
        for (int i = 0; i < 22; i++) begin
            RESETN = tbl[i].rstn;
            CLK_EN = tbl[i].en;
            step();
            chk($sformatf("vec%0d h", i),  int'(bus_s.VGA_horzCoord), tbl[i].h);
            chk($sformatf("vec%0d v", i),  int'(bus_s.VGA_vertCoord), tbl[i].v);
            chk($sformatf("vec%0d hs", i), int'(bus_s.HSYNC), int'(tbl[i].hs));
            chk($sformatf("vec%0d vs", i), int'(bus_s.VSYNC), int'(tbl[i].vs));
            chk($sformatf("vec%0d va", i), int'(bus_s.VIDEO_ACTIVE), int'(tbl[i].va));
            chk($sformatf("vec%0d fs", i), int'(bus_s.FRAME_START), int'(tbl[i].fs));
            if (i <= 2) begin
                chk($sformatf("vec%0d dflt h", i), int'(bus_d.VGA_horzCoord), i + 1);
            end
        end

        // ---------------- full line (default) and full frames (small) ----------------
        RESETN = 1'b0;
        CLK_EN = 1'b1;
        step();
        RESETN = 1'b1;
        d_va = 0; d_hs = 0; d_vs = 0; d_hs_first = -1; d_hs_last = -1;
        y_hs_first = -1; y_va_fall = -1; y_va_prev = 1'b0;
        s_va = 0; s_vs = 0; s_vs_first = -1; s_fs = 0;
        for (int k = 1; k <= 1700; k++) begin
            step();
            if (k <= 1688) begin
                if (bus_d.VIDEO_ACTIVE) d_va++;
                if (bus_d.VSYNC) d_vs++;
                if (bus_d.HSYNC) begin
                    d_hs++;
                    if (d_hs_first < 0) d_hs_first = int'(bus_d.VGA_horzCoord);
                    d_hs_last = int'(bus_d.VGA_horzCoord);
                end
            end
            if (k == 1279) chk("line va at 1279", int'(bus_d.VIDEO_ACTIVE), 1);
            if (k == 1280) chk("line va at 1280", int'(bus_d.VIDEO_ACTIVE), 0);
            if (k == 1687) begin
                chk("line end h", int'(bus_d.VGA_horzCoord), 1687);
                chk("line end v", int'(bus_d.VGA_vertCoord), 0);
            end
            if (k == 1688) begin
                chk("line wrap h", int'(bus_d.VGA_horzCoord), 0);
                chk("line wrap v", int'(bus_d.VGA_vertCoord), 1);
            end
            if (bus_y.HSYNC && y_hs_first < 0) y_hs_first = int'(bus_y.VGA_horzCoord);
            if (y_va_prev && !bus_y.VIDEO_ACTIVE && y_va_fall < 0) y_va_fall = int'(bus_y.VGA_horzCoord);
            y_va_prev = bus_y.VIDEO_ACTIVE;

            if (k <= 128) begin
                if (bus_s.VIDEO_ACTIVE) s_va++;
                if (!bus_s.VSYNC) begin
                    s_vs++;
                    if (s_vs_first < 0) s_vs_first = k;
                end
            end
            if (bus_s.FRAME_START) s_fs++;
            if (k == 127) begin
                chk("frame last h", int'(bus_s.VGA_horzCoord), 15);
                chk("frame last v", int'(bus_s.VGA_vertCoord), 7);
                chk("frame last fs", int'(bus_s.FRAME_START), 0);
            end
            if (k == 128) begin
                chk("frame wrap h", int'(bus_s.VGA_horzCoord), 0);
                chk("frame wrap v", int'(bus_s.VGA_vertCoord), 0);
                chk("frame wrap fs", int'(bus_s.FRAME_START), 1);
                chk("frame wrap fc", int'(bus_s.FRAME_COUNT), FC_ONE);
            end
            if (k == 129) chk("frame fs drop", int'(bus_s.FRAME_START), 0);
            if (k == 256) chk("frame2 fc", int'(bus_s.FRAME_COUNT), FC_TWO);
        end
        chk("line va count", d_va, 1280);
        chk("line hs count", d_hs, 112);
        chk("line hs first h", d_hs_first, 1328);
        chk("line hs last h", d_hs_last, 1439);
        chk("line vs count", d_vs, 0);
        chk("dly hs rise h", y_hs_first, 1330);
        chk("dly va fall h", y_va_fall, 1282);
        chk("frame va count", s_va, 32);
        chk("frame vs count", s_vs, 32);
        chk("frame vs first", s_vs_first, 80);
        chk("frame fs count", s_fs, 13);

        // ---------------- CLK_EN toggling 1,0,1,0 ----------------
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        fs_n = 0; fs_first = -1; fs_second = -1;
        for (int e = 1; e <= 600; e++) begin
            CLK_EN = (e % 2) == 1;
            step();
            if (bus_s.FRAME_START) begin
                fs_n++;
                if (fs_first < 0) fs_first = e;
                else if (fs_second < 0) fs_second = e;
            end
            if (e == 256) chk("gate fs next clk", int'(bus_s.FRAME_START), 0);
            if (e == 256) chk("gate hold h", int'(bus_s.VGA_horzCoord), 0);
        end
        CLK_EN = 1'b1;
        chk("gate fs first edge", fs_first, 255);
        chk("gate frame period", fs_second - fs_first, 256);
        chk("gate fs cycles", fs_n, 2);

        // ---------------- async reset mid-frame ----------------
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        repeat (181) step();
        chk("mid h", int'(bus_s.VGA_horzCoord), 5);
        chk("mid v", int'(bus_s.VGA_vertCoord), 3);
        chk("mid fc", int'(bus_s.FRAME_COUNT), FC_ONE);
        #2;
        RESETN = 1'b0;
        #1;
        chk("async small h", int'(bus_s.VGA_horzCoord), 0);
        chk("async small v", int'(bus_s.VGA_vertCoord), 0);
        chk("async small va", int'(bus_s.VIDEO_ACTIVE), 0);
        chk("async small hs", int'(bus_s.HSYNC), 1);
        chk("async small fc", int'(bus_s.FRAME_COUNT), 0);
        chk("async dflt h", int'(bus_d.VGA_horzCoord), 0);
        chk("async dflt va", int'(bus_d.VIDEO_ACTIVE), 0);
        step();
        RESETN = 1'b1;
        step();
        chk("restart small h", int'(bus_s.VGA_horzCoord), 1);
        chk("restart small v", int'(bus_s.VGA_vertCoord), 0);
        chk("restart small fs", int'(bus_s.FRAME_START), 0);
        chk("restart dflt h", int'(bus_d.VGA_horzCoord), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_coord_gen.md
Name: vga_coord_gen

Overview:
- Pixel-timing front end of the display path: generates VGA_horzCoord / VGA_vertCoord for all on-screen overlay condition blocks (labels, grid, waveform), plus HSYNC, VSYNC and active-video qualifiers for the colour mux and the output pins.
- Default timing is 1280x1024 @ 60 Hz at a 108 MHz pixel rate.
- A CLK_EN input allows operation from a faster system clock.
- A configurable sync delay aligns HSYNC/VSYNC with the registered colour path downstream.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, horizontal sync width (pixels)
- H_BP, 248, horizontal back porch (pixels); H_TOTAL = sum = 1688
- V_ACTIVE, 1024, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines); V_TOTAL = 1066
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
- SYNC_DELAY, 0, extra pixel-enable cycles of delay on HSYNC/VSYNC/VIDEO_ACTIVE, range 0..4

Ports:
- CLK  in  1  pixel or system clock
- RESETN  in  1  asynchronous active-low reset
- CLK_EN  in  1  pixel advance enable; tie 1 when CLK is the pixel clock
- VGA_horzCoord  out  12  current horizontal count, 0..H_TOTAL-1
- VGA_vertCoord  out  12  current vertical count, 0..V_TOTAL-1
- HSYNC  out  1  horizontal sync, polarity per SYNC_POL
- VSYNC  out  1  vertical sync, polarity per SYNC_POL
- VIDEO_ACTIVE  out  1  high when both counts are inside the active area
- FRAME_START  out  1  one-CLK pulse when counts move to (0,0)
- FRAME_COUNT  out  16  frames completed (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - VGA_horzCoord = 0, VGA_vertCoord = 0, FRAME_START = 0, FRAME_COUNT = 0.
  - VIDEO_ACTIVE = 0 and HSYNC/VSYNC inactive (= !SYNC_POL).
  - All sync-delay stages cleared to the same values.
- Counters advance only on CLK edges with CLK_EN = 1. With CLK_EN = 0, every output and delay stage holds, except FRAME_START, which is 0.
- Horizontal counter:
  - h increments by 1.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At h = H_TOTAL-1 and v = V_TOTAL-1, both wrap to 0.
- Coordinates are registered counter values. Downstream compare blocks see the coordinate valid from the cycle it appears.
- Qualifiers (undelayed), decoded from the next-state counts so they are coincident with the coordinates at SYNC_DELAY = 0:
  - HSYNC active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 1328..1439.
  - VSYNC active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 1025..1027, for the full line width.
  - VIDEO_ACTIVE when h < H_ACTIVE and v < V_ACTIVE.
- SYNC_DELAY = N > 0: HSYNC, VSYNC and VIDEO_ACTIVE pass through an N-stage shift register that advances on CLK_EN. Coordinates are never delayed.
- FRAME_START:
  - High for exactly one CLK cycle, the cycle in which the outputs first show (0,0) after a wrap.
  - Not asserted on reset release.
- Width rule: all compares are 12-bit unsigned. H_TOTAL and V_TOTAL must be <= 4096; elaboration fails otherwise via a generate-time check.
- Reset mid-frame: counters return to (0,0) immediately, with no partial-line completion. The first frame after release is a full frame.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - FRAME_COUNT increments by 1 on each FRAME_START and wraps 65535 -> 0.
  - Intended for display blinking and acquisition pacing.
- Undefined: FRAME_COUNT is tied to 16'd0 and no counter logic is synthesised. The port remains for interface stability.

Test Plan:
- Reset values: hold RESETN = 0 with CLK_EN = 1 -> coords (0,0), HSYNC = VSYNC = 0 (SYNC_POL = 1), VIDEO_ACTIVE = 0, FRAME_COUNT = 0. Release -> coords 1,2,3 on the next three edges.
- Line timing, SYNC_DELAY = 0: run one line -> VIDEO_ACTIVE high for h 0..1279; HSYNC high exactly for h 1328..1439 (112 cycles); h wraps 1687 -> 0 with v 0 -> 1.
- Frame wrap: run to (1687,1065) -> next edge gives (0,0) with FRAME_START = 1 for one cycle. VSYNC high for lines 1025..1027 (3 x 1688 = 5064 cycles). FRAME_COUNT = 1 with VGA_FRAME_COUNT_EN, 0 without.
- CLK_EN gating: CLK_EN toggling 1,0,1,0 -> coords advance every second CLK; total frame = 2 x 1688 x 1066 CLKs; FRAME_START lasts one CLK only.
- SYNC_DELAY = 2: HSYNC rises two enabled cycles after VGA_horzCoord = 1328, i.e. while VGA_horzCoord = 1330. VIDEO_ACTIVE falls while VGA_horzCoord = 1282.
- Async reset mid-frame: assert RESETN = 0 at (700,512) between clock edges -> outputs go to reset values without a clock edge; after release, counting restarts at (0,0); FRAME_COUNT is cleared.
